// File: rtl/uart_mmio_ctr_pkg.sv
// Register map, error-bit indices and register decode shared by the UART MMIO controller.
package uart_mmio_ctr_pkg;

    localparam logic [3:0] DEFAULT_ADDR_TAG = 4'b1000;

    localparam logic [7:0] UART_TX_STAT = 8'h00;
    localparam logic [7:0] UART_RX_STAT = 8'h04;
    localparam logic [7:0] UART_RX_DATA = 8'h08;
    localparam logic [7:0] UART_TX_DATA = 8'h0C;
    localparam logic [7:0] UART_CYCLE   = 8'h10;
    localparam logic [7:0] UART_ERR     = 8'h14;

    localparam int ERR_UFL = 0;
    localparam int ERR_OFL = 1;
    localparam int ERR_ILL = 2;

    typedef enum logic [2:0] {
        REG_TX_STAT,
        REG_RX_STAT,
        REG_RX_DATA,
        REG_TX_DATA,
        REG_CYCLE,
        REG_ERR,
        REG_NONE
    } regSel_e;

    function automatic regSel_e decodeReg(input logic [7:0] off);
        case (off)
            UART_TX_STAT: return REG_TX_STAT;
            UART_RX_STAT: return REG_RX_STAT;
            UART_RX_DATA: return REG_RX_DATA;
            UART_TX_DATA: return REG_TX_DATA;
            UART_CYCLE:   return REG_CYCLE;
            UART_ERR:     return REG_ERR;
            default:      return REG_NONE;
        endcase
    endfunction

    function automatic logic isReadable(input regSel_e r);
        return r inside {REG_TX_STAT, REG_RX_STAT, REG_RX_DATA, REG_CYCLE, REG_ERR};
    endfunction

    function automatic logic isWritable(input regSel_e r);
        return r inside {REG_TX_DATA, REG_CYCLE};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wrData,
    output logic [WIDTH-1:0] rdData,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic             doPush;
    logic             doPop;

    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) && (wrPtr[AW] != rdPtr[AW]);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign rdData = mem[rdPtr[AW-1:0]];

    // NOTE: sequential state uses <= so every flop samples pre-edge values, making push/pop order-independent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + (AW+1)'(1);
            if (doPop)  rdPtr <= rdPtr + (AW+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= wrData;
    end

endmodule

// File: rtl/uart_mmio_ctr.sv
// Memory-stage MMIO controller: per-channel UART RX/TX FIFOs, sticky error flags and a cycle counter.
module uart_mmio_ctr
    import uart_mmio_ctr_pkg::*;
#(
    parameter int         NUM_CH     = 2,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [3:0] ADDR_TAG   = DEFAULT_ADDR_TAG
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         addr,
    input  logic                rd_en,
    input  logic                wr_en,
    input  logic [31:0]         wr_data,
    output logic                hit,
    output logic [31:0]         rdata,
    output logic [NUM_CH-1:0]   DataInValid,
    input  logic [NUM_CH-1:0]   DataInReady,
    output logic [8*NUM_CH-1:0] DataIn,
    input  logic [NUM_CH-1:0]   DataOutValid,
    output logic [NUM_CH-1:0]   DataOutReady,
    input  logic [8*NUM_CH-1:0] DataOut,
    output logic                err
);

    logic [3:0]                chIdx;
    regSel_e                   regSel;
    logic                      chOk;
    logic                      rdOk;
    logic                      wrOk;
    logic                      illegal;
    logic [31:0]               cycleCnt;
    logic [NUM_CH-1:0]         txFull;
    logic [NUM_CH-1:0]         txEmpty;
    logic [NUM_CH-1:0]         rxFull;
    logic [NUM_CH-1:0]         rxEmpty;
    logic [NUM_CH-1:0][7:0]    rxHead;
    logic [NUM_CH-1:0][2:0]    errVec;
    logic                      selTxFull;
    logic                      selRxEmpty;
    logic [7:0]                selRxHead;
    logic [2:0]                selErr;
    logic                      unusedBits;

    assign unusedBits = ^{wr_data[31:8], addr[27:12]};

    assign hit    = (addr[31:28] == ADDR_TAG);
    assign chIdx  = addr[11:8];
    assign regSel = decodeReg(addr[7:0]);
    assign chOk   = int'(chIdx) < NUM_CH;
    assign rdOk   = hit && rd_en && chOk && isReadable(regSel);
    // A simultaneous read wins the access; the write half is then illegal.
    assign wrOk   = hit && wr_en && !rd_en && chOk && isWritable(regSel);
    assign illegal = (hit && rd_en && !rdOk) || (hit && wr_en && !wrOk);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycleCnt <= '0;
        end else if (wrOk && regSel == REG_CYCLE) begin
            cycleCnt <= '0;
        end else begin
            cycleCnt <= cycleCnt + 32'd1;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : gCh
        logic       sel;
        logic       txPush;
        logic       rxPop;
        logic       errClr;
        logic [2:0] errEvt;
        logic [2:0] errQ;

        assign sel    = (chIdx == 4'(c));
        assign txPush = wrOk && sel && (regSel == REG_TX_DATA);
        assign rxPop  = rdOk && sel && (regSel == REG_RX_DATA);
        assign errClr = rdOk && sel && (regSel == REG_ERR);

        sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) uTxFifo (
            .clk    (clk),
            .reset  (reset),
            .push   (txPush),
            .pop    (DataInReady[c]),
            .wrData (wr_data[7:0]),
            .rdData (DataIn[8*c +: 8]),
            .full   (txFull[c]),
            .empty  (txEmpty[c])
        );

        sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) uRxFifo (
            .clk    (clk),
            .reset  (reset),
            .push   (DataOutValid[c]),
            .pop    (rxPop),
            .wrData (DataOut[8*c +: 8]),
            .rdData (rxHead[c]),
            .full   (rxFull[c]),
            .empty  (rxEmpty[c])
        );

        assign DataInValid[c]  = !txEmpty[c];
        assign DataOutReady[c] = !rxFull[c];

        always_comb begin
            errEvt          = '0;
            errEvt[ERR_UFL] = rxPop && rxEmpty[c];
            errEvt[ERR_OFL] = txPush && txFull[c];
            errEvt[ERR_ILL] = (c == 0) && illegal;
        end

        // A read of the flags clears them, but an event in the same cycle still lands.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                errQ <= '0;
            end else begin
                errQ <= (errClr ? 3'b000 : errQ) | errEvt;
            end
        end

        assign errVec[c] = errQ;
    end

    assign err = |errVec;

    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    always_comb begin
        selTxFull  = 1'b0;
        selRxEmpty = 1'b1;
        selRxHead  = '0;
        selErr     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (chIdx == 4'(c)) begin
                selTxFull  = txFull[c];
                selRxEmpty = rxEmpty[c];
                selRxHead  = rxHead[c];
                selErr     = errVec[c];
            end
        end

        rdata = '0;
        if (rdOk) begin
            case (regSel)
                REG_TX_STAT: rdata = {31'b0, !selTxFull};
                REG_RX_STAT: rdata = {31'b0, !selRxEmpty};
                REG_RX_DATA: rdata = selRxEmpty ? 32'b0 : {24'b0, selRxHead};
                REG_CYCLE:   rdata = cycleCnt;
                REG_ERR:     rdata = {29'b0, selErr};
                default:     rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mmio_ctr.sv
// Directed, scoreboard-based bench for uart_mmio_ctr with two channels and 8-deep FIFOs.
module tb_uart_mmio_ctr;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        hit;
    logic [31:0] rdata;
    logic [1:0]  DataInValid;
    logic [1:0]  DataInReady;
    logic [15:0] DataIn;
    logic [1:0]  DataOutValid;
    logic [1:0]  DataOutReady;
    logic [15:0] DataOut;
    logic        err;

    int nErr    = 0;
    int nChecks = 0;

    logic [7:0] txQ0[$];
    logic [7:0] txQ1[$];
    logic [7:0] rxQ0[$];
    logic [7:0] rxQ1[$];

    uart_mmio_ctr #(.NUM_CH(2), .FIFO_DEPTH(8), .ADDR_TAG(4'b1000)) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .rd_en        (rd_en),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .hit          (hit),
        .rdata        (rdata),
        .DataInValid  (DataInValid),
        .DataInReady  (DataInReady),
        .DataIn       (DataIn),
        .DataOutValid (DataOutValid),
        .DataOutReady (DataOutReady),
        .DataOut      (DataOut),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mmioRead(input logic [31:0] a, output logic [31:0] d);
        addr  = a;
        rd_en = 1'b1;
        #1 d  = rdata;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        mmioRead(a, d);
        check(tag, d, exp);
    endtask

    task automatic mmioWrite(input logic [31:0] a, input logic [31:0] d);
        addr    = a;
        wr_data = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic txPop(input int c, input logic [7:0] obs);
        int         n;
        logic [7:0] expB;
        n = (c == 0) ? txQ0.size() : txQ1.size();
        check("tx_pending", 32'(n != 0), 32'd1);
        if (n != 0) begin
            if (c == 0) expB = txQ0.pop_front();
            else        expB = txQ1.pop_front();
            check("tx_byte", {24'b0, obs}, {24'b0, expB});
        end
    endtask

    // Handshakes are observed mid-cycle, where inputs and registered outputs are stable.
    always @(negedge clk) begin
        if (reset) begin
            if (DataInValid[0] && DataInReady[0]) txPop(0, DataIn[7:0]);
            if (DataInValid[1] && DataInReady[1]) txPop(1, DataIn[15:8]);
            if (DataOutValid[0] && DataOutReady[0]) rxQ0.push_back(DataOut[7:0]);
            if (DataOutValid[1] && DataOutReady[1]) rxQ1.push_back(DataOut[15:8]);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v1;
        logic [31:0] v2;
        logic [7:0]  expB;

        reset        = 1'b0;
        addr         = '0;
        rd_en        = 1'b0;
        wr_en        = 1'b0;
        wr_data      = '0;
        DataInReady  = '0;
        DataOutValid = '0;
        DataOut      = '0;

        #12;
        check("rst_tx_valid", 32'(DataInValid), 32'h0);
        check("rst_rx_ready", 32'(DataOutReady), 32'h3);
        check("rst_err", 32'(err), 32'h0);
        addr = 32'h8000_0000;
        #1 check("hit_match", 32'(hit), 32'h1);
        addr = 32'h4000_0000;
        #1 check("hit_miss", 32'(hit), 32'h0);
        tick();
        reset = 1'b1;
        tick();

        // TX ch0: one byte, held until the transmitter is ready.
        mmioWrite(32'h8000_000C, 32'h0000_0041);
        txQ0.push_back(8'h41);
        check("tx0_valid_after_push", 32'(DataInValid[0]), 32'h1);
        check("tx0_data_after_push", 32'(DataIn[7:0]), 32'h41);
        DataInReady[0] = 1'b1;
        tick();
        check("tx0_valid_drop", 32'(DataInValid[0]), 32'h0);
        DataInReady[0] = 1'b0;

        // TX ch1: fill, then overflow with a 9th byte.
        for (int i = 0; i < 8; i++) begin
            mmioWrite(32'h8000_010C, 32'(8'h10 + i));
            txQ1.push_back(8'(8'h10 + i));
        end
        mmioWrite(32'h8000_010C, 32'h0000_0099);
        check("ofl_err_out", 32'(err), 32'h1);
        readCheck("tx1_stat_full", 32'h8000_0100, 32'h0);
        readCheck("tx1_err_ofl", 32'h8000_0114, 32'h2);
        check("err_cleared", 32'(err), 32'h0);
        DataInReady[1] = 1'b1;
        repeat (10) tick();
        DataInReady[1] = 1'b0;
        check("tx1_drained", 32'(DataInValid[1]), 32'h0);

        // RX ch0: fill to back-pressure, then one CPU pop reopens it.
        DataOut[7:0]    = 8'h5A;
        DataOutValid[0] = 1'b1;
        repeat (8) tick();
        check("rx0_ready_full", 32'(DataOutReady[0]), 32'h0);
        expB = rxQ0.pop_front();
        readCheck("rx0_first_pop", 32'h8000_0008, {24'b0, expB});
        check("rx0_ready_back", 32'(DataOutReady[0]), 32'h1);
        DataOutValid[0] = 1'b0;

        // RX ch1: acceptance visible in status one cycle later.
        DataOut[15:8]   = 8'hC3;
        DataOutValid[1] = 1'b1;
        tick();
        DataOutValid[1] = 1'b0;
        readCheck("rx1_stat_latency", 32'h8000_0104, 32'h1);
        expB = rxQ1.pop_front();
        readCheck("rx1_data", 32'h8000_0108, {24'b0, expB});
        readCheck("rx1_stat_empty", 32'h8000_0104, 32'h0);

        for (int i = 0; i < 7; i++) begin
            expB = rxQ0.pop_front();
            readCheck("rx0_drain", 32'h8000_0008, {24'b0, expB});
        end
        readCheck("rx0_stat_empty", 32'h8000_0004, 32'h0);

        // Underflow and clear-on-read.
        readCheck("rx0_empty_read", 32'h8000_0008, 32'h0);
        readCheck("err_ufl", 32'h8000_0014, 32'h1);
        readCheck("err_ufl_cleared", 32'h8000_0014, 32'h0);

        // Miss: not claimed, no side effects.
        addr  = 32'h4000_0008;
        rd_en = 1'b1;
        #1;
        check("miss_hit", 32'(hit), 32'h0);
        check("miss_rdata", rdata, 32'h0);
        tick();
        rd_en = 1'b0;
        readCheck("miss_no_err", 32'h8000_0014, 32'h0);

        // Illegal accesses all land on channel 0.
        readCheck("ill_ch_read", 32'h8000_0310, 32'h0);
        check("ill_err_out", 32'(err), 32'h1);
        readCheck("err_ill", 32'h8000_0014, 32'h4);
        mmioWrite(32'h8000_0004, 32'h1);
        readCheck("ill_wo_read", 32'h8000_000C, 32'h0);
        readCheck("err_ill_type", 32'h8000_0014, 32'h4);
        readCheck("err_ill_cleared", 32'h8000_0014, 32'h0);

        // Read+write together: the read clears, the illegal write sets ERR_ILL and wins.
        addr    = 32'h8000_0014;
        wr_data = 32'h0;
        rd_en   = 1'b1;
        wr_en   = 1'b1;
        #1 check("rdwr_rdata", rdata, 32'h0);
        tick();
        rd_en = 1'b0;
        wr_en = 1'b0;
        readCheck("rdwr_ill_wins", 32'h8000_0014, 32'h4);

        // Cycle counter: increments per cycle, a write clears it.
        mmioRead(32'h8000_0010, v1);
        mmioRead(32'h8000_0010, v2);
        check("cycle_incr", v2, v1 + 32'd1);
        mmioWrite(32'h8000_0110, 32'hDEAD_BEEF);
        readCheck("cycle_cleared", 32'h8000_0010, 32'h0);
        readCheck("cycle_restart", 32'h8000_0010, 32'h1);

        // Reset mid-stream discards queued TX bytes and sticky flags.
        for (int i = 0; i < 3; i++) begin
            mmioWrite(32'h8000_000C, 32'(8'hA1 + i));
            txQ0.push_back(8'(8'hA1 + i));
        end
        readCheck("pre_rst_ill", 32'h8000_0018, 32'h0);
        check("pre_rst_err", 32'(err), 32'h1);
        #3 reset = 1'b0;
        #1;
        check("rst_async_tx_valid", 32'(DataInValid), 32'h0);
        check("rst_async_err", 32'(err), 32'h0);
        txQ0.delete();
        DataInReady = 2'b11;
        repeat (3) tick();
        reset = 1'b1;
        readCheck("post_rst_tx_stat", 32'h8000_0000, 32'h1);
        readCheck("post_rst_rx_stat", 32'h8000_0004, 32'h0);
        readCheck("post_rst_err0", 32'h8000_0014, 32'h0);
        readCheck("post_rst_err1", 32'h8000_0114, 32'h0);
        repeat (4) tick();
        check("post_rst_tx_idle", 32'(DataInValid), 32'h0);
        check("post_rst_rx_ready", 32'(DataOutReady), 32'h3);
        DataInReady = 2'b00;

        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end

endmodule

// File: doc/uart_mmio_ctr.md
Name: uart_mmio_ctr

Overview:
- Parametrised memory-mapped I/O controller for the pipeline memory stage, for one or more UART channels.
- Each channel has an RX FIFO and a TX FIFO, so the CPU never waits on UART handshakes.
- Also provides per-channel sticky status/error flags and a free-running cycle counter.
- Claims every access whose address matches ADDR_TAG in bits [31:28]; it returns read data in the same cycle and commits FIFO pops/pushes at the clock edge.

Parameters:
- NUM_CH, 2: number of UART channels, 1..16.
- FIFO_DEPTH, 8: entries per RX and per TX FIFO; a power of two, at least 2.
- ADDR_TAG, 4'b1000: value of addr[31:28] that selects this block.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- addr  in  32  memory-stage address (ALU output).
- rd_en  in  1  memory-stage load is valid.
- wr_en  in  1  memory-stage store is valid.
- wr_data  in  32  store data; only bits [7:0] are used for TX data.
- hit  out  1  addr[31:28]==ADDR_TAG; combinational.
- rdata  out  32  read data; combinational.
- DataInValid  out  NUM_CH  per-channel TX byte valid toward the UART transmitter.
- DataInReady  in  NUM_CH  UART transmitter accepts a byte.
- DataIn  out  8*NUM_CH  TX byte; channel c uses bits [8c+7:8c].
- DataOutValid  in  NUM_CH  UART receiver has a byte.
- DataOutReady  out  NUM_CH  this block accepts the RX byte.
- DataOut  in  8*NUM_CH  RX byte, packed like DataIn.
- err  out  1  OR of all per-channel error sticky bits.

Behaviour:
- Decode:
  - ch = addr[11:8]; reg = addr[7:0].
  - A hit with ch >= NUM_CH or an unmapped reg is illegal.
  - Illegal reads return 0. Illegal writes are ignored. Either sets ERR_ILL of channel 0.
- Registers (per channel):
  - 0x00 TX status, read: bit0 = TX FIFO not full.
  - 0x04 RX status, read: bit0 = RX FIFO not empty.
  - 0x08 RX data, read: {24'b0, head}. The pop happens at the clock edge when rd_en & hit.
    - Read while empty returns 0, does not pop, and sets ERR_UFL.
  - 0x0C TX data, write: push wr_data[7:0] at the clock edge.
    - Write while full is dropped and sets ERR_OFL.
  - 0x10 cycle counter, read: 32-bit count, wraps 0xFFFFFFFF->0.
    - Any write clears it to 0 at the next edge; the counter does not increment in that cycle.
  - 0x14 error flags, read: {29'b0, ERR_ILL, ERR_OFL, ERR_UFL}.
    - A read clears all three at the edge.
    - If a new error event occurs in that same cycle, it wins and its bit stays set.
- Access type mismatches: reads of write-only registers and writes of read-only registers are illegal.
- rd_en and wr_en together with a hit: the write is ignored and ERR_ILL is set; the read proceeds.
- TX path:
  - DataInValid[c] = TX FIFO not empty; DataIn = FIFO head.
  - Pop when DataInValid & DataInReady.
  - Push and pop in the same cycle are both performed; when the FIFO is full, the push is judged on pre-edge occupancy and is dropped.
- RX path:
  - DataOutReady[c] = RX FIFO not full; push when DataOutValid & DataOutReady.
  - No data loss: the UART holds the byte until it is accepted.
  - A CPU pop and a UART push in the same cycle are both performed.
- FIFOs: pointers are log2(FIFO_DEPTH)+1 bits wide with a wrap bit; full = indices equal and wrap bits differ.
- Reset (reset low, asynchronous):
  - All FIFO pointers = 0, counter = 0, sticky bits = 0.
  - DataInValid = 0, DataOutReady = all 1s, err = 0.
  - FIFO contents are don't-care.
  - Reset mid-transfer discards queued bytes. No partial state survives.
- Latency:
  - A pushed TX byte appears on DataIn 1 cycle after the push edge.
  - An accepted RX byte is visible in the RX status 1 cycle after acceptance.

Decomposition:
- Shared package/header uart_mmio.vh holds:
  - register offsets (UART_TX_STAT, UART_RX_STAT, UART_RX_DATA, UART_TX_DATA, UART_CYCLE, UART_ERR);
  - error bit indices;
  - the default ADDR_TAG.
- One sub-module, sync_fifo (WIDTH, DEPTH), instantiated 2*NUM_CH times via a generate loop.

Test Plan:
- Write 0x8000_000C data 0x41 with DataInReady[0]=0 -> next cycle DataInValid[0]=1, DataIn[7:0]=0x41. Raise DataInReady -> DataInValid drops the cycle after.
- Push 8 bytes to ch1 TX (0x8000_010C) with ready low, then a 9th write of 0x99 -> read 0x8000_0100 = 0; 0x8000_0114 = 0x2; err=1; the 9th byte is never transmitted.
- Present DataOutValid[0] with 0x5A held for 8 accepted bytes -> DataOutReady[0]=0 on the 9th. Read 0x8000_0008 -> 0x5A, and DataOutReady returns to 1 next cycle.
- Read 0x8000_0008 with the RX FIFO empty -> rdata=0, no pop, ERR_UFL set. Read 0x8000_0014 -> 0x1, a second read -> 0x0.
- Read 0x8000_0310 with NUM_CH=2 -> rdata=0, ERR_ILL set. Write any value to 0x8000_0010 -> a subsequent read returns a small count, not continuing from the old value.
- Assert reset low mid-stream with 3 TX bytes queued -> DataInValid=0 immediately, all status reads 0/empty after release, and no queued byte is emitted.
